// File: rtl/piccolo_pkg.sv
// Shared constants, FSM state type and round-key index helper for the Piccolo round controller.
package piccolo_pkg;

   localparam int R80   = 25;
   localparam int R128  = 31;
   localparam int CNT_W = 5;

   localparam logic [CNT_W-1:0] LAST80  = CNT_W'(R80 - 1);
   localparam logic [CNT_W-1:0] LAST128 = CNT_W'(R128 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Key pairs are consumed two at a time, so the index is doubled; decryption walks them backwards.
   function automatic logic [CNT_W:0] rk_index(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] last,
                                               input logic             dec);
      logic [CNT_W-1:0] k;
      k = dec ? (last - cnt) : cnt;
      return {k, 1'b0};
   endfunction

endpackage

// File: rtl/piccolo_round_ctrl_if.sv
// Host-side job/result handshake of the Piccolo round controller.
// PICCOLO_DECRYPT_EN adds the dec request bit.
interface piccolo_round_ctrl_if;
   logic in_valid;
   logic in_ready;
   logic key_sel;
   logic out_valid;
   logic out_ready;
`ifdef PICCOLO_DECRYPT_EN
   logic dec;

   modport master (output in_valid, key_sel, dec, out_ready, input in_ready, out_valid);
   modport slave  (input in_valid, key_sel, dec, out_ready, output in_ready, out_valid);
`else
   modport master (output in_valid, key_sel, out_ready, input in_ready, out_valid);
   modport slave  (input in_valid, key_sel, out_ready, output in_ready, out_valid);
`endif
endinterface

// File: rtl/piccolo_rk_index.sv
// Combinational round-key pair index from round counter, latched last round and direction.
module piccolo_rk_index
   import piccolo_pkg::*;
(
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] last,
   input  logic             dec,
   output logic [CNT_W:0]   rk_idx
);

   assign rk_idx = rk_index(cnt, last, dec);

endmodule

// File: rtl/piccolo_round_ctrl.sv
// Sequencer for the iterated Piccolo datapath: accept job, run 25/31 rounds, hold result.
// PICCOLO_DECRYPT_EN enables reverse round-key ordering via the dec request bit.
module piccolo_round_ctrl
   import piccolo_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   piccolo_round_ctrl_if.slave  host,
   output logic                 ld_state,
   output logic                 en_round,
   output logic                 rp_en,
   output logic                 wk_final,
   output logic [CNT_W-1:0]     round_idx,
   output logic [CNT_W:0]       rk_idx,
   output logic                 busy
);

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [CNT_W-1:0] last, nxt_last;
   logic             dec_q, nxt_dec;
   logic             dec_in, accept;

   logic             en_round_n, rp_en_n, wk_final_n, out_valid_n, busy_n;
   logic [CNT_W-1:0] round_idx_n;
   logic [CNT_W:0]   rk_n, rk_idx_n;

`ifdef PICCOLO_DECRYPT_EN
   assign dec_in = host.dec;
`else
   assign dec_in = 1'b0;
`endif

   assign host.in_ready = (state == IDLE);
   assign accept        = host.in_valid && (state == IDLE);
   assign ld_state      = accept;

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         last           <= '0;
         dec_q          <= 1'b0;
         en_round       <= 1'b0;
         rp_en          <= 1'b0;
         wk_final       <= 1'b0;
         host.out_valid <= 1'b0;
         busy           <= 1'b0;
         round_idx      <= '0;
         rk_idx         <= '0;
      end else begin
         state          <= nxt_state;
         cnt            <= nxt_cnt;
         last           <= nxt_last;
         dec_q          <= nxt_dec;
         en_round       <= en_round_n;
         rp_en          <= rp_en_n;
         wk_final       <= wk_final_n;
         host.out_valid <= out_valid_n;
         busy           <= busy_n;
         round_idx      <= round_idx_n;
         rk_idx         <= rk_idx_n;
      end
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_last  = last;
      nxt_dec   = dec_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               nxt_state = ROUND;
               nxt_cnt   = '0;
               nxt_last  = host.key_sel ? LAST128 : LAST80;
               nxt_dec   = dec_in;
            end
         end
         ROUND: begin
            if (cnt == last) nxt_state = DONE;
            else             nxt_cnt   = cnt + 1'b1;
         end
         DONE: begin
            if (host.out_ready) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   piccolo_rk_index u_rk_index (
      .cnt    (nxt_cnt),
      .last   (nxt_last),
      .dec    (nxt_dec),
      .rk_idx (rk_n)
   );

   always_comb begin
      en_round_n  = (nxt_state == ROUND);
      rp_en_n     = en_round_n && (nxt_cnt != nxt_last);
      wk_final_n  = en_round_n && (nxt_cnt == nxt_last);
      out_valid_n = (nxt_state == DONE);
      busy_n      = (nxt_state != IDLE);
      round_idx_n = en_round_n ? nxt_cnt : '0;
      rk_idx_n    = en_round_n ? rk_n : '0;
   end

endmodule
